a10_mac_dot_accum: RTL and testbench
====================================

A10_MAC_DOT_ACCUM -- requirements
Module: a10_mac_dot_accum

Interface
REQ-001 The block SHALL have parameter LANES, default 4: number of multiplier lanes, legal range 1..16.
REQ-002 The block SHALL have parameter DATA_W, default 8: operand width, legal range 2..18.
REQ-003 The block SHALL have parameter ACC_W, default 32: accumulator width, required to be at least SUM_W = 2*DATA_W+clog2(LANES).
REQ-004 The block SHALL have parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clock0  in  1  single clock, rising edge.
- aclr0  in  1  reset, asynchronous, active-high.
- ena  in  1  pipeline enable; 0 freezes all stages.
- valid_in  in  1  operand beat valid.
- clear_in  in  1  first beat of a new accumulation.
- last_in  in  1  final beat of the accumulation.
- dataa  in  LANES*DATA_W  operand A; lane i occupies bits [i*DATA_W +: DATA_W].
- datab  in  LANES*DATA_W  operand B, packed the same way.
- result  out  ACC_W  accumulated dot product.
- result_valid  out  1  one-cycle pulse: result holds a completed accumulation.
- sat  out  ACC_W-wide? no: 1 bit; sticky saturation flag for the current accumulation.

Function
REQ-006 The datapath SHALL be four register stages: S1 input registers, S2 per-lane products, S3 adder-tree sum (SUM_W bits), S4 accumulator.
REQ-007 The latency from a valid_in beat to its contribution at result, and to result_valid, SHALL be exactly 4 enabled cycles.
REQ-008 valid_in, clear_in and last_in SHALL travel alongside the data as sideband bits through every stage.
REQ-009 When ena=0, no stage register or sideband bit SHALL change, and result_valid SHALL be held low.
REQ-010 Beats with valid_in=0 SHALL leave the accumulator unchanged; clear_in and last_in SHALL be ignored on such beats.
REQ-011 On a valid S3 beat with clear=1, the accumulator SHALL load the extended S3 sum: sign-extended if SIGNED=1, zero-extended otherwise.
REQ-012 On a valid S3 beat with clear=0, the accumulator SHALL load the accumulator plus the extended sum.
REQ-013 If the result of REQ-012 exceeds the ACC_W range, the accumulator SHALL saturate to the signed max/min (SIGNED=1) or to all-ones (SIGNED=0), and sat SHALL be set.
REQ-014 sat SHALL be cleared by a clear beat unless that clear beat itself saturates; otherwise it SHALL stay set until the next clear beat.
REQ-015 A beat carrying both clear_in and last_in SHALL be treated as a single-beat accumulation: load per REQ-011, then pulse result_valid.
REQ-016 result_valid SHALL pulse for exactly one cycle on the cycle after a valid last beat updates the accumulator.
REQ-017 result SHALL remain stable until the next valid S3 beat.
REQ-018 Back-to-back accumulations SHALL be supported: a clear beat that directly follows a last beat incurs no bubble.
REQ-019 Products SHALL be full-width 2*DATA_W with no truncation.
REQ-020 The adder tree SHALL NOT overflow at SUM_W bits.

Reset
REQ-021 While aclr0 is asserted, all stage registers, sidebands, result, result_valid and sat SHALL go to 0 immediately, independent of clock0.
REQ-022 Deassertion of aclr0 SHALL take effect on the next rising edge of clock0.
REQ-023 An accumulation in flight when aclr0 asserts SHALL be discarded, and no result_valid SHALL be issued for it.

Structure
REQ-024 A shared package SHALL hold the SUM_W computation function, the saturation-limit constants and the lane-slice helper.
REQ-025 The per-lane multiplier plus S1/S2 registers SHALL be one sub-module, a10_mac_lane, instantiated LANES times.

Verification
REQ-026 Config LANES=4, DATA_W=8, SIGNED=1, ACC_W=32: one beat with clear=last=1, A={1,2,3,4}, B={5,6,7,8} -> result=70 with a result_valid pulse exactly 4 cycles later; sat=0.
REQ-027 Three beats (clear, -, last), each with A=all -128 and B=all -128 -> result=196608, single result_valid pulse.
REQ-028 ACC_W=18, repeated beats with A=all 127, B=all 127 (64516 per beat) -> result saturates to 131071, sat=1; the next clear beat returns sat to 0.
REQ-029 Toggle ena=0 for 3 cycles mid-stream -> result identical to the no-stall run, and result_valid is delayed by exactly 3 cycles.
REQ-030 Assert aclr0 asynchronously between clock edges during an accumulation -> outputs go to 0 at once, no result_valid follows, and the next clear/last beat yields a correct fresh result.
REQ-031 SIGNED=0, A=all 255, B=all 255, single beat -> result=260100.

Source files
------------

// File: rtl/a10_mac_dot_accum_pkg.sv
// Shared widths, saturation limits and lane-slicing helper for the a10 MAC dot-product accumulator.
package a10_mac_dot_accum_pkg;

  localparam int unsigned MAX_LANES  = 16;
  localparam int unsigned MAX_DATA_W = 18;
  localparam int unsigned MAX_ACC_W  = 64;

  typedef struct packed {
    logic valid;
    logic clear;
    logic last;
  } sb_t;

  // Width of the adder-tree sum; wide enough that LANES full-width products never overflow.
  function automatic int unsigned sum_width(input int unsigned lanes, input int unsigned data_w);
    return 2 * data_w + $clog2(lanes);
  endfunction

  function automatic logic [MAX_ACC_W-1:0] sat_hi(input int unsigned acc_w, input bit is_signed);
    logic [MAX_ACC_W-1:0] ones;
    ones = '1;
    return ones >> (MAX_ACC_W - acc_w + (is_signed ? 1 : 0));
  endfunction

  function automatic logic [MAX_ACC_W-1:0] sat_lo(input int unsigned acc_w, input bit is_signed);
    logic [MAX_ACC_W-1:0] one;
    one = MAX_ACC_W'(1);
    return is_signed ? (one << (acc_w - 1)) : '0;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] lane_slice(
    input logic [MAX_LANES*MAX_DATA_W-1:0] bus,
    input int unsigned                      lane,
    input int unsigned                      data_w
  );
    logic [MAX_DATA_W-1:0] mask;
    mask = '1;
    mask = mask >> (MAX_DATA_W - data_w);
    return MAX_DATA_W'(bus >> (lane * data_w)) & mask;
  endfunction

endpackage

// File: rtl/a10_mac_dot_accum_lane.sv
// One multiplier lane: S1 operand registers followed by the S2 full-width product register.
module a10_mac_lane
  import a10_mac_dot_accum_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SIGNED = 1
) (
  input  logic                  clock0,
  input  logic                  aclr0,
  input  logic                  ena,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   prod
);

  logic [DATA_W-1:0]   a_r, b_r;
  logic [2*DATA_W-1:0] a_x, b_x, prod_c;

  // Operands widened to the product width so the low 2*DATA_W bits are exact in both modes.
  generate
    if (SIGNED != 0) begin : g_sext
      assign a_x = {{DATA_W{a_r[DATA_W-1]}}, a_r};
      assign b_x = {{DATA_W{b_r[DATA_W-1]}}, b_r};
    end else begin : g_zext
      assign a_x = {{DATA_W{1'b0}}, a_r};
      assign b_x = {{DATA_W{1'b0}}, b_r};
    end
  endgenerate

  assign prod_c = a_x * b_x;

  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      a_r  <= '0;
      b_r  <= '0;
      prod <= '0;
    end else if (ena) begin
      a_r  <= a;
      b_r  <= b;
      prod <= prod_c;
    end
  end

endmodule

// File: rtl/a10_mac_dot_accum.sv
// Four-stage pipelined dot-product MAC: lane multipliers, adder tree, saturating accumulator.
module a10_mac_dot_accum
  import a10_mac_dot_accum_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned SIGNED = 1
) (
  input  logic                      clock0,
  input  logic                      aclr0,
  input  logic                      ena,
  input  logic                      valid_in,
  input  logic                      clear_in,
  input  logic                      last_in,
  input  logic [LANES*DATA_W-1:0]   dataa,
  input  logic [LANES*DATA_W-1:0]   datab,
  output logic [ACC_W-1:0]          result,
  output logic                      result_valid,
  output logic                      sat
);

  localparam int unsigned SUM_W     = sum_width(LANES, DATA_W);
  localparam bit          IS_SIGNED = (SIGNED != 0);
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_hi(ACC_W, IS_SIGNED));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_lo(ACC_W, IS_SIGNED));

  logic [DATA_W-1:0]   lane_a [LANES];
  logic [DATA_W-1:0]   lane_b [LANES];
  logic [2*DATA_W-1:0] prod   [LANES];

  sb_t                 sb_in, sb1, sb2, sb3;
  logic [SUM_W-1:0]    sum_c, sum3;
  logic [ACC_W-1:0]    acc, acc_n;
  logic                sat_r, sat_n, rv_r;
  logic [ACC_W:0]      sum_x, acc_x, cand;
  logic                ovf, ovf_neg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_a[gi] = DATA_W'(lane_slice((MAX_LANES*MAX_DATA_W)'(dataa), gi, DATA_W));
      assign lane_b[gi] = DATA_W'(lane_slice((MAX_LANES*MAX_DATA_W)'(datab), gi, DATA_W));

      a10_mac_lane #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
      ) u_lane (
        .clock0 (clock0),
        .aclr0  (aclr0),
        .ena    (ena),
        .a      (lane_a[gi]),
        .b      (lane_b[gi]),
        .prod   (prod[gi])
      );
    end
  endgenerate

  assign sb_in = '{valid: valid_in, clear: clear_in, last: last_in};

  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum_c = sum_c + (IS_SIGNED ? SUM_W'($signed(prod[i])) : SUM_W'(prod[i]));
    end
  end

  // One guard bit above ACC_W exposes overflow for both the clear load and the running add.
  always_comb begin
    sum_x   = IS_SIGNED ? (ACC_W+1)'($signed(sum3)) : (ACC_W+1)'(sum3);
    acc_x   = IS_SIGNED ? {acc[ACC_W-1], acc} : {1'b0, acc};
    cand    = sb3.clear ? sum_x : (acc_x + sum_x);
    ovf     = IS_SIGNED ? (cand[ACC_W] != cand[ACC_W-1]) : cand[ACC_W];
    ovf_neg = IS_SIGNED & cand[ACC_W];
    acc_n   = cand[ACC_W-1:0];
    if (ovf) begin
      acc_n = ovf_neg ? ACC_MIN : ACC_MAX;
    end
    sat_n   = sb3.clear ? ovf : (sat_r | ovf);
  end

  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      sb1   <= '0;
      sb2   <= '0;
      sb3   <= '0;
      sum3  <= '0;
      acc   <= '0;
      sat_r <= 1'b0;
      rv_r  <= 1'b0;
    end else if (ena) begin
      sb1  <= sb_in;
      sb2  <= sb1;
      sb3  <= sb2;
      sum3 <= sum_c;
      rv_r <= sb3.valid & sb3.last;
      if (sb3.valid) begin
        acc   <= acc_n;
        sat_r <= sat_n;
      end
    end else begin
      rv_r <= 1'b0;
    end
  end

  assign result       = acc;
  assign sat          = sat_r;
  assign result_valid = rv_r;

endmodule

// File: tb/tb_a10_mac_dot_accum.sv
// Scoreboard bench: three configurations share one stimulus stream, checked against an arithmetic model.
module tb_a10_mac_dot_accum;

  logic        clk = 1'b0;
  logic        rst, ena, valid_in, clear_in, last_in;
  logic [31:0] dataa, datab;
  logic [31:0] res_a, res_u;
  logic [17:0] res_s;
  logic        rv_a, rv_s, rv_u, sat_a, sat_s, sat_u;

  a10_mac_dot_accum #(.LANES(4), .DATA_W(8), .ACC_W(32), .SIGNED(1)) dut_a (
    .clock0(clk), .aclr0(rst), .ena(ena), .valid_in(valid_in), .clear_in(clear_in),
    .last_in(last_in), .dataa(dataa), .datab(datab), .result(res_a),
    .result_valid(rv_a), .sat(sat_a));

  a10_mac_dot_accum #(.LANES(4), .DATA_W(8), .ACC_W(18), .SIGNED(1)) dut_s (
    .clock0(clk), .aclr0(rst), .ena(ena), .valid_in(valid_in), .clear_in(clear_in),
    .last_in(last_in), .dataa(dataa), .datab(datab), .result(res_s),
    .result_valid(rv_s), .sat(sat_s));

  a10_mac_dot_accum #(.LANES(4), .DATA_W(8), .ACC_W(32), .SIGNED(0)) dut_u (
    .clock0(clk), .aclr0(rst), .ena(ena), .valid_in(valid_in), .clear_in(clear_in),
    .last_in(last_in), .dataa(dataa), .datab(datab), .result(res_u),
    .result_valid(rv_u), .sat(sat_u));

  always #5 clk = ~clk;

  typedef struct {
    longint      res;
    bit          sat;
    int unsigned tag;
  } exp_t;

  exp_t        sbq [3][$];
  longint      m_acc [3];
  bit          m_sat [3];
  int unsigned en_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int unsigned cfg_w(input int k);
    return (k == 1) ? 18 : 32;
  endfunction

  function automatic bit cfg_s(input int k);
    return (k != 2);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      sbq[k].delete();
      m_acc[k] = 0;
      m_sat[k] = 1'b0;
    end
  endfunction

  function automatic void model_beat(input bit c, input bit l, input logic [31:0] a,
                                     input logic [31:0] b, input int unsigned tag);
    for (int k = 0; k < 3; k++) begin
      longint dot = 0;
      longint hi, lo, s;
      bit     o;
      int unsigned w = cfg_w(k);
      for (int i = 0; i < 4; i++) begin
        logic [7:0] xa, xb;
        xa = a[8*i +: 8];
        xb = b[8*i +: 8];
        if (cfg_s(k)) dot += longint'($signed(xa)) * longint'($signed(xb));
        else          dot += longint'(xa) * longint'(xb);
      end
      hi = cfg_s(k) ? ((longint'(1) << (w - 1)) - 1) : ((longint'(1) << w) - 1);
      lo = cfg_s(k) ? -(longint'(1) << (w - 1)) : 0;
      s  = c ? dot : (m_acc[k] + dot);
      o  = (s > hi) || (s < lo);
      m_acc[k] = (s > hi) ? hi : ((s < lo) ? lo : s);
      m_sat[k] = c ? o : (m_sat[k] | o);
      if (l) sbq[k].push_back('{res: m_acc[k] & ((longint'(1) << w) - 1), sat: m_sat[k], tag: tag});
    end
  endfunction

  function automatic void chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endfunction

  function automatic void mon(input int k, input logic rv, input longint r, input logic s);
    exp_t e;
    if (rv !== 1'b0) begin
      n_cmp++;
      if (sbq[k].size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rv dut%0d: result_valid=%b result=%0d with nothing expected", k, rv, r);
      end else begin
        e = sbq[k].pop_front();
        if (rv !== 1'b1 || r != e.res || s !== e.sat || en_cnt != e.tag) begin
          n_bad++;
          $display("FAIL result dut%0d: got result=%0d sat=%b at en_cycle %0d, expected result=%0d sat=%0d at en_cycle %0d",
                   k, r, s, en_cnt, e.res, e.sat, e.tag);
        end
      end
    end
  endfunction

  always @(posedge clk) if (!rst && ena) en_cnt++;

  always @(negedge clk) begin
    mon(0, rv_a, longint'(res_a), sat_a);
    mon(1, rv_s, longint'(res_s), sat_s);
    mon(2, rv_u, longint'(res_u), sat_u);
  end

  task automatic drive(input bit en, input bit v, input bit c, input bit l,
                       input logic [31:0] a, input logic [31:0] b);
    ena = en; valid_in = v; clear_in = c; last_in = l; dataa = a; datab = b;
    if (en && v) model_beat(c, l, a, b, en_cnt + 4);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_res_a"}, longint'(res_a), 0);
    chk({tag, "_res_s"}, longint'(res_s), 0);
    chk({tag, "_res_u"}, longint'(res_u), 0);
    chk({tag, "_rv"},    longint'({rv_a, rv_s, rv_u}), 0);
    chk({tag, "_sat"},   longint'({sat_a, sat_s, sat_u}), 0);
  endtask

  localparam logic [31:0] A1234 = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [31:0] B5678 = {8'd8, 8'd7, 8'd6, 8'd5};

  initial begin
    rst = 1'b1; ena = 1'b0; valid_in = 1'b0; clear_in = 1'b0; last_in = 1'b0;
    dataa = '0; datab = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    idle(2);

    // single beat with clear and last
    drive(1, 1, 1, 1, A1234, B5678);
    idle(6);
    chk("dot70_a", longint'(res_a), 70);
    chk("dot70_sat_a", longint'(sat_a), 0);
    chk("dot70_u", longint'(res_u), 70);

    // three beats of -128 * -128
    drive(1, 1, 1, 0, 32'h80808080, 32'h80808080);
    drive(1, 1, 0, 0, 32'h80808080, 32'h80808080);
    drive(1, 1, 0, 1, 32'h80808080, 32'h80808080);
    idle(6);
    chk("neg128_a", longint'(res_a), 196608);
    chk("neg128_s", longint'(res_s), 131071);
    chk("neg128_sat_s", longint'(sat_s), 1);

    // back-to-back: clear immediately after last
    drive(1, 1, 1, 0, 32'h01010101, 32'h01010101);
    drive(1, 1, 0, 1, 32'h01010101, 32'h01010101);
    drive(1, 1, 1, 1, A1234, B5678);
    drive(1, 1, 1, 0, A1234, B5678);
    drive(1, 1, 0, 1, A1234, B5678);
    idle(6);
    chk("b2b_a", longint'(res_a), 140);

    // saturation at ACC_W=18 then recovery on clear
    drive(1, 1, 1, 0, 32'h7f7f7f7f, 32'h7f7f7f7f);
    drive(1, 1, 0, 0, 32'h7f7f7f7f, 32'h7f7f7f7f);
    drive(1, 1, 0, 0, 32'h7f7f7f7f, 32'h7f7f7f7f);
    drive(1, 1, 0, 1, 32'h7f7f7f7f, 32'h7f7f7f7f);
    idle(6);
    chk("sat_res_s", longint'(res_s), 131071);
    chk("sat_flag_s", longint'(sat_s), 1);
    chk("nosat_res_a", longint'(res_a), 258064);
    drive(1, 1, 1, 1, A1234, B5678);
    idle(6);
    chk("satclr_flag_s", longint'(sat_s), 0);
    chk("satclr_res_s", longint'(res_s), 70);

    // stalls mid-stream: stalled beats carry junk with valid=1 and must not count
    drive(1, 1, 1, 0, A1234, B5678);
    repeat (3) drive(0, 1, 1, 1, 32'hffffffff, 32'h7f7f7f7f);
    drive(1, 1, 0, 1, A1234, B5678);
    idle(1);
    repeat (3) drive(0, 1, 0, 1, $urandom, $urandom);
    idle(6);
    chk("stall_a", longint'(res_a), 140);

    // unsigned all-ones
    drive(1, 1, 1, 1, 32'hffffffff, 32'hffffffff);
    idle(6);
    chk("unsigned_255", longint'(res_u), 260100);
    chk("signed_m1_a", longint'(res_a), 4);

    // asynchronous reset with an accumulation in flight
    drive(1, 1, 1, 1, A1234, B5678);
    idle(6);
    drive(1, 1, 1, 0, 32'h11111111, 32'h22222222);
    drive(1, 1, 0, 1, 32'h33333333, 32'h44444444);
    ena = 1'b1; valid_in = 1'b0; clear_in = 1'b0; last_in = 1'b0;
    chk("pre_rst_a", longint'(res_a), 70);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(8);
    drive(1, 1, 1, 1, A1234, 32'h01010101);
    idle(6);
    chk("post_rst_a", longint'(res_a), 10);

    // randomized traffic with stalls
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom, $urandom);
    end
    drive(1, 1, 0, 1, $urandom, $urandom);
    idle(8);
    for (int k = 0; k < 3; k++) chk($sformatf("drain_dut%0d", k), longint'(sbq[k].size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
